alu_shift_sequencer: RTL and testbench

//  Multi-bit shift/rotate sequencer placed directly upstream of the ALU, on its A operand and FunSel/WF.

---
 rtl/alu_seq_pkg.sv | 57 +++++
 rtl/alu_shift_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_shift_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU shift sequencer.
package alu_seq_pkg;

    localparam int unsigned OP_W     = 3;
    localparam int unsigned FS_W     = 4;
    localparam int unsigned FLAGS_W  = 4;
    localparam int unsigned NARROW_W = 8;

    // Requested shift/rotate operation; encodings 5..7 are illegal.
    typedef enum logic [OP_W-1:0] {
        OP_LSL = 3'd0,
        OP_LSR = 3'd1,
        OP_ASR = 3'd2,
        OP_CSL = 3'd3,
        OP_CSR = 3'd4
    } op_e;

    // ALU function-select codes (low four bits of FunSel).
    localparam logic [FS_W-1:0] FS_LSL = 4'b1011;
    localparam logic [FS_W-1:0] FS_LSR = 4'b1100;
    localparam logic [FS_W-1:0] FS_ASR = 4'b1101;
    localparam logic [FS_W-1:0] FS_CSL = 4'b1110;
    localparam logic [FS_W-1:0] FS_CSR = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit positions inside the {Z,C,N,O} flag word.
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_O = 0;

    // True for the five defined operations.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op <= 3'(OP_CSR));
    endfunction

    // Map an operation to its ALU function code; illegal ops map to 0.
    function automatic logic [FS_W-1:0] op_to_funsel(input logic [OP_W-1:0] op);
        logic [FS_W-1:0] fs;
        fs = '0;
        case (op)
            3'(OP_LSL): fs = FS_LSL;
            3'(OP_LSR): fs = FS_LSR;
            3'(OP_ASR): fs = FS_ASR;
            3'(OP_CSL): fs = FS_CSL;
            3'(OP_CSR): fs = FS_CSR;
            default:    fs = '0;
        endcase
        return fs;
    endfunction

endpackage

// File: rtl/alu_shift_sequencer.sv
// Multi-bit shift/rotate sequencer driving the ALU one single-bit shift per cycle.
// Optional feature: define ALU_SEQ_ABORT_EN to add an Abort input that ends a
// running shift early with the partial result and RspErr set.
module alu_shift_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               ReqValid,
    output logic               ReqReady,
    input  logic [2:0]         ReqOp,
    input  logic               ReqWide,
    input  logic [CNT_W-1:0]   ReqCount,
    input  logic [DATA_W-1:0]  ReqData,
`ifdef ALU_SEQ_ABORT_EN
    input  logic               Abort,
`endif
    output logic [DATA_W-1:0]  AluA,
    output logic [4:0]         AluFunSel,
    output logic               AluWF,
    input  logic [DATA_W-1:0]  AluOut,
    input  logic [3:0]         AluFlags,
    output logic               RspValid,
    input  logic               RspReady,
    output logic [DATA_W-1:0]  RspData,
    output logic [3:0]         RspFlags,
    output logic               RspErr
);

    // 8-bit operations keep only the low byte of the working register.
    localparam logic [DATA_W-1:0] NARROW_MASK = DATA_W'({NARROW_W{1'b1}});

    state_e            state_q, state_d;
    logic [DATA_W-1:0] work_q,  work_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [OP_W-1:0]   op_q,    op_d;
    logic              wide_q,  wide_d;
    logic              err_q,   err_d;

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            wide_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            wide_q  <= wide_d;
            err_q   <= err_d;
        end
    end

    // Next-state, datapath update and port outputs.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        wide_d    = wide_q;
        err_d     = err_q;

        ReqReady  = 1'b0;
        AluA      = work_q;
        AluFunSel = '0;
        AluWF     = 1'b0;
        RspValid  = 1'b0;
        RspData   = '0;
        RspFlags  = '0;
        RspErr    = 1'b0;

        case (state_q)
            IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    work_d = ReqWide ? ReqData : (ReqData & NARROW_MASK);
                    cnt_d  = ReqCount;
                    op_d   = ReqOp;
                    wide_d = ReqWide;
                    err_d  = !op_legal(ReqOp);
                    if ((ReqCount == '0) || !op_legal(ReqOp)) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                AluFunSel = {wide_q, op_to_funsel(op_q)};
                AluWF     = 1'b1;
                work_d    = wide_q ? AluOut : (AluOut & NARROW_MASK);
                // cnt is never zero here, but never let it wrap regardless.
                cnt_d     = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : cnt_q;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = DONE;
                end
`ifdef ALU_SEQ_ABORT_EN
                // The shift issued this cycle still lands so work and flags agree.
                if (Abort) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
`endif
            end

            DONE: begin
                RspValid = 1'b1;
                RspData  = work_q;
                RspFlags = AluFlags;
                RspErr   = err_q;
                if (RspReady) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Self-checking bench for alu_shift_sequencer with a behavioural shift ALU.
module tb_alu_shift_sequencer;

    logic        Clock;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [2:0]  ReqOp;
    logic        ReqWide;
    logic [3:0]  ReqCount;
    logic [15:0] ReqData;
    logic [15:0] AluA;
    logic [4:0]  AluFunSel;
    logic        AluWF;
    logic [15:0] AluOut;
    logic [3:0]  AluFlags;
    logic        RspValid;
    logic        RspReady;
    logic [15:0] RspData;
    logic [3:0]  RspFlags;
    logic        RspErr;
`ifdef ALU_SEQ_ABORT_EN
    logic        Abort;
`endif

    int n_checks;
    int n_fail;

    alu_shift_sequencer #(.DATA_W(16), .CNT_W(4)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqOp     (ReqOp),
        .ReqWide   (ReqWide),
        .ReqCount  (ReqCount),
        .ReqData   (ReqData),
`ifdef ALU_SEQ_ABORT_EN
        .Abort     (Abort),
`endif
        .AluA      (AluA),
        .AluFunSel (AluFunSel),
        .AluWF     (AluWF),
        .AluOut    (AluOut),
        .AluFlags  (AluFlags),
        .RspValid  (RspValid),
        .RspReady  (RspReady),
        .RspData   (RspData),
        .RspFlags  (RspFlags),
        .RspErr    (RspErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural ALU: single-bit shifts; flags {Z,C,N,O}, O left untouched.
    function automatic logic [19:0] alu_eval(input logic [15:0] a, input logic [4:0] fs,
                                             input logic [3:0] fl);
        logic [15:0] r;
        logic [7:0]  b;
        logic        c;
        logic        hit;
        r = a; c = fl[2]; hit = 1'b1; b = a[7:0];
        if (fs[4]) begin
            case (fs[3:0])
                4'b1011: begin c = a[15]; r = {a[14:0], 1'b0};  end
                4'b1100: begin c = a[0];  r = {1'b0, a[15:1]};  end
                4'b1101: begin c = a[0];  r = {a[15], a[15:1]}; end
                4'b1110: begin c = a[15]; r = {a[14:0], fl[2]}; end
                4'b1111: begin c = a[0];  r = {fl[2], a[15:1]}; end
                default: hit = 1'b0;
            endcase
        end else begin
            case (fs[3:0])
                4'b1011: begin c = b[7]; r = {8'h00, b[6:0], 1'b0}; end
                4'b1100: begin c = b[0]; r = {8'h00, 1'b0, b[7:1]}; end
                4'b1101: begin c = b[0]; r = {8'h00, b[7], b[7:1]}; end
                4'b1110: begin c = b[7]; r = {8'h00, b[6:0], fl[2]}; end
                4'b1111: begin c = b[0]; r = {8'h00, fl[2], b[7:1]}; end
                default: hit = 1'b0;
            endcase
        end
        if (!hit) return {fl, a};
        return {(r == 16'h0), c, (fs[4] ? r[15] : r[7]), fl[0], r};
    endfunction

    logic [3:0] flags_q;
    logic [3:0] flags_next;
    logic       preset_en;
    logic [3:0] preset_val;

    assign {flags_next, AluOut} = alu_eval(AluA, AluFunSel, flags_q);
    assign AluFlags = flags_q;

    // ALU flag register; the bench can preset it to seed the carry.
    always @(posedge Clock or negedge Reset) begin
        if (!Reset)          flags_q <= 4'h0;
        else if (preset_en)  flags_q <= preset_val;
        else if (AluWF)      flags_q <= flags_next;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_flags(input logic [3:0] v);
        @(negedge Clock);
        preset_en = 1'b1; preset_val = v;
        @(negedge Clock);
        preset_en = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (!ReqReady && k < 50) begin
            @(negedge Clock);
            k++;
        end
        if (!ReqReady) check({nm, "_ready_timeout"}, 32'(ReqReady), 32'd1);
    endtask

    // Present one request for a single accept edge.
    task automatic send(input logic [2:0] op, input logic wide, input logic [3:0] cnt,
                        input logic [15:0] data);
        ReqValid = 1'b1; ReqOp = op; ReqWide = wide; ReqCount = cnt; ReqData = data;
        @(negedge Clock);
        ReqValid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic        wide;
        logic [3:0]  cnt;
        logic [15:0] data;
        logic [3:0]  seed;
        logic [15:0] exp_data;
        logic [3:0]  exp_flags;
        logic        exp_err;
        logic [4:0]  exp_fs;
        int          exp_lat;
        int          exp_wf;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    initial begin
        int lat, wf, seen_valid;
        logic [4:0] fs_seen;
        logic [15:0] d_hold;
        logic [3:0]  f_hold;

        n_checks = 0; n_fail = 0;
        Reset = 1'b0; ReqValid = 1'b0; ReqOp = '0; ReqWide = 1'b0; ReqCount = '0;
        ReqData = '0; RspReady = 1'b1; preset_en = 1'b0; preset_val = '0;
`ifdef ALU_SEQ_ABORT_EN
        Abort = 1'b0;
`endif

        //            op    w     cnt    data      seed   exp_data  flags  err   fs        lat wf
        vecs[0]  = '{3'd0, 1'b1, 4'd4,  16'h0001, 4'h0, 16'h0010, 4'h0, 1'b0, 5'b11011, 5,  4};
        vecs[1]  = '{3'd1, 1'b0, 4'd1,  16'h0081, 4'h0, 16'h0040, 4'h4, 1'b0, 5'b01100, 2,  1};
        vecs[2]  = '{3'd0, 1'b1, 4'd0,  16'h1234, 4'h0, 16'h1234, 4'h0, 1'b0, 5'b00000, 1,  0};
        vecs[3]  = '{3'd2, 1'b1, 4'd3,  16'h8000, 4'h0, 16'hF000, 4'h2, 1'b0, 5'b11101, 4,  3};
        vecs[4]  = '{3'd3, 1'b1, 4'd2,  16'h8001, 4'h4, 16'h0007, 4'h0, 1'b0, 5'b11110, 3,  2};
        vecs[5]  = '{3'd4, 1'b0, 4'd1,  16'h0001, 4'h0, 16'h0000, 4'hC, 1'b0, 5'b01111, 2,  1};
        vecs[6]  = '{3'd5, 1'b1, 4'd3,  16'hBEEF, 4'h0, 16'hBEEF, 4'h0, 1'b1, 5'b00000, 1,  0};
        vecs[7]  = '{3'd0, 1'b0, 4'd15, 16'h1281, 4'h0, 16'h0000, 4'h8, 1'b0, 5'b01011, 16, 15};
        vecs[8]  = '{3'd1, 1'b1, 4'd15, 16'hFFFF, 4'h0, 16'h0001, 4'h4, 1'b0, 5'b11100, 16, 15};
        vecs[9]  = '{3'd2, 1'b0, 4'd2,  16'h00F0, 4'h0, 16'h00FC, 4'h2, 1'b0, 5'b01101, 3,  2};
        vecs[10] = '{3'd6, 1'b1, 4'd0,  16'h0F0F, 4'h0, 16'h0F0F, 4'h0, 1'b1, 5'b00000, 1,  0};
        vecs[11] = '{3'd0, 1'b1, 4'd1,  16'h4000, 4'h1, 16'h8000, 4'h3, 1'b0, 5'b11011, 2,  1};

        // Reset state.
        #12;
        check("rst_req_ready", 32'(ReqReady), 32'd1);
        check("rst_rsp_valid", 32'(RspValid), 32'd0);
        check("rst_alu_wf",    32'(AluWF),    32'd0);
        check("rst_funsel",    32'(AluFunSel), 32'd0);
        check("rst_alu_a",     32'(AluA),     32'd0);
        check("rst_rsp_data",  32'(RspData),  32'd0);
        check("rst_rsp_flags", 32'(RspFlags), 32'd0);
        check("rst_rsp_err",   32'(RspErr),   32'd0);
        @(negedge Clock);
        Reset = 1'b1;

        // Table-driven requests.
        for (int i = 0; i < NV; i++) begin
            set_flags(vecs[i].seed);
            wait_ready($sformatf("v%0d", i));
            send(vecs[i].op, vecs[i].wide, vecs[i].cnt, vecs[i].data);
            lat = 1; wf = 0; fs_seen = '0;
            while (!RspValid && lat < 40) begin
                if (AluWF) begin
                    if (wf == 0) fs_seen = AluFunSel;
                    wf++;
                end
                @(negedge Clock);
                lat++;
            end
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_wf_cycles", i), 32'(wf), 32'(vecs[i].exp_wf));
            check($sformatf("v%0d_funsel", i), 32'(fs_seen), 32'(vecs[i].exp_fs));
            check($sformatf("v%0d_data", i), 32'(RspData), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_flags", i), 32'(RspFlags), 32'(vecs[i].exp_flags));
            check($sformatf("v%0d_err", i), 32'(RspErr), 32'(vecs[i].exp_err));
            @(negedge Clock);
            check($sformatf("v%0d_rsp_drop", i), 32'(RspValid), 32'd0);
        end

        // Response backpressure: outputs hold and no request is taken in DONE.
        set_flags(4'h0);
        wait_ready("bp");
        RspReady = 1'b0;
        send(3'd0, 1'b1, 4'd1, 16'h0003);
        @(negedge Clock);
        check("bp_valid", 32'(RspValid), 32'd1);
        check("bp_data",  32'(RspData),  32'h0006);
        check("bp_flags", 32'(RspFlags), 32'h0);
        d_hold = RspData; f_hold = RspFlags;
        ReqValid = 1'b1; ReqOp = 3'd1; ReqWide = 1'b1; ReqCount = 4'd2; ReqData = 16'hAAAA;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            check($sformatf("bp_hold%0d_valid", k), 32'(RspValid), 32'd1);
            check($sformatf("bp_hold%0d_data", k),  32'(RspData),  32'(d_hold));
            check($sformatf("bp_hold%0d_flags", k), 32'(RspFlags), 32'(f_hold));
            check($sformatf("bp_hold%0d_ready", k), 32'(ReqReady), 32'd0);
            check($sformatf("bp_hold%0d_wf", k),    32'(AluWF),    32'd0);
        end
        ReqValid = 1'b0;
        RspReady = 1'b1;
        @(negedge Clock);
        check("bp_idle_valid", 32'(RspValid), 32'd0);
        check("bp_idle_ready", 32'(ReqReady), 32'd1);

        // Reset in the middle of a long shift.
        set_flags(4'h0);
        wait_ready("mid");
        send(3'd0, 1'b1, 4'd10, 16'h0001);
        @(negedge Clock);
        @(negedge Clock);
        check("mid_shifting", 32'(AluWF), 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("mid_req_ready", 32'(ReqReady), 32'd1);
        check("mid_alu_wf",    32'(AluWF),    32'd0);
        check("mid_funsel",    32'(AluFunSel), 32'd0);
        check("mid_alu_a",     32'(AluA),     32'd0);
        check("mid_rsp_valid", 32'(RspValid), 32'd0);
        check("mid_rsp_data",  32'(RspData),  32'd0);
        check("mid_rsp_err",   32'(RspErr),   32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        seen_valid = 0; wf = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge Clock);
            if (RspValid) seen_valid++;
            if (AluWF) wf++;
        end
        check("mid_no_stale_rsp", 32'(seen_valid), 32'd0);
        check("mid_no_stale_wf",  32'(wf),         32'd0);
        check("mid_ready_after",  32'(ReqReady),   32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
